// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage and register file.
package wb_pkg;

    // Write-back source select encodings (MD field of the pipeline register)
    typedef enum logic [1:0] {
        MD_ALU = 2'd0,
        MD_MEM = 2'd1,
        MD_SLT = 2'd2,
        MD_RSV = 2'd3
    } md_sel_e;

    // Hard-wired zero register index
    localparam int unsigned ZERO_REG = 0;

endpackage : wb_pkg

// File: rtl/three_to_one_mux.sv
// Three-input selector used for the write-back value.
// The unused fourth select code falls back to in0.
module three_to_one_mux
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_s;

    // Pick one input by sel; reserved code maps to in0
    always_comb begin
        out_s = in0;
        case (sel)
            MD_ALU:  out_s = in0;
            MD_MEM:  out_s = in1;
            MD_SLT:  out_s = in2;
            MD_RSV:  out_s = in0;
            default: out_s = in0;
        endcase
    end

    assign out = out_s;

endmodule : three_to_one_mux

// File: rtl/writeback_regfile.sv
// Write-back stage plus register file for the pipelined MIPS datapath.
// Selects the write-back value, commits it to the array, and serves two
// decode read ports with execute- and write-back-stage forwarding.
module writeback_regfile
    import wb_pkg::*;
#(
    parameter int DATA_BITS      = 32,
    parameter int reg_addr_width = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RW_WB,
    input  logic [reg_addr_width-1:0] DA_WB,
    input  logic [1:0]                MD_WB,
    input  logic [DATA_BITS-1:0]      result,
    input  logic                      determinate,
    input  logic [DATA_BITS-1:0]      DData_next,
    input  logic                      RW_EX,
    input  logic [reg_addr_width-1:0] DA_EX,
    input  logic [DATA_BITS-1:0]      forward_data,
    input  logic [reg_addr_width-1:0] AA,
    input  logic [reg_addr_width-1:0] BA,
    output logic [DATA_BITS-1:0]      A_data,
    output logic [DATA_BITS-1:0]      B_data,
    output logic [31:0]               wb_count
);

    localparam int DEPTH = 1 << reg_addr_width;
    localparam logic [reg_addr_width-1:0] ZERO_ADDR = reg_addr_width'(ZERO_REG);

    logic [DATA_BITS-1:0] regs_r [DEPTH];
    logic [31:0]          wb_count_r;
    logic [DATA_BITS-1:0] wb_data_s;
    logic [DATA_BITS-1:0] slt_ext_s;
    logic                 commit_s;
    logic [DATA_BITS-1:0] a_data_s;
    logic [DATA_BITS-1:0] b_data_s;

    assign slt_ext_s = {{(DATA_BITS-1){1'b0}}, determinate};

    three_to_one_mux #(
        .WIDTH (DATA_BITS)
    ) u_wb_mux (
        .sel (MD_WB),
        .in0 (result),
        .in1 (DData_next),
        .in2 (slt_ext_s),
        .out (wb_data_s)
    );

    // Writes to the zero register are dropped entirely (no commit, no count)
    assign commit_s = RW_WB && (DA_WB != ZERO_ADDR);

    // Register array: cleared on reset, one write per cycle, r0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_BITS{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[DA_WB] <= wb_data_s;
        end else begin
            regs_r[DA_WB] <= regs_r[DA_WB];
        end
    end

    // Committed-write counter, wraps modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_r <= 32'd0;
        end else if (commit_s) begin
            wb_count_r <= wb_count_r + 32'd1;
        end else begin
            wb_count_r <= wb_count_r;
        end
    end

    // One read port: zero reg, then execute forward (youngest), then
    // write-back write-through, then the array.
    function automatic logic [DATA_BITS-1:0] read_port(
        input logic [reg_addr_width-1:0] addr
    );
        logic [DATA_BITS-1:0] val;
        if (addr == ZERO_ADDR) begin
            val = {DATA_BITS{1'b0}};
        end else if (RW_EX && (DA_EX == addr)) begin
            val = forward_data;
        end else if (RW_WB && (DA_WB == addr)) begin
            val = wb_data_s;
        end else begin
            val = regs_r[addr];
        end
        return val;
    endfunction

    // Operand A read with bypass
    always_comb begin
        a_data_s = {DATA_BITS{1'b0}};
        a_data_s = read_port(AA);
    end

    // Operand B read with bypass
    always_comb begin
        b_data_s = {DATA_BITS{1'b0}};
        b_data_s = read_port(BA);
    end

    assign A_data   = a_data_s;
    assign B_data   = b_data_s;
    assign wb_count = wb_count_r;

endmodule : writeback_regfile

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: stimulus pushes expected read-port
// and counter values into a queue, a negedge monitor pops and compares.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        RW_WB;
    logic [4:0]  DA_WB;
    logic [1:0]  MD_WB;
    logic [31:0] result;
    logic        determinate;
    logic [31:0] DData_next;
    logic        RW_EX;
    logic [4:0]  DA_EX;
    logic [31:0] forward_data;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic [31:0] A_data;
    logic [31:0] B_data;
    logic [31:0] wb_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          ca;
        logic [31:0] a;
        bit          cb;
        logic [31:0] b;
        bit          cc;
        logic [31:0] c;
    } exp_t;

    exp_t exp_q[$];

    writeback_regfile #(
        .DATA_BITS      (32),
        .reg_addr_width (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RW_WB        (RW_WB),
        .DA_WB        (DA_WB),
        .MD_WB        (MD_WB),
        .result       (result),
        .determinate  (determinate),
        .DData_next   (DData_next),
        .RW_EX        (RW_EX),
        .DA_EX        (DA_EX),
        .forward_data (forward_data),
        .AA           (AA),
        .BA           (BA),
        .A_data       (A_data),
        .B_data       (B_data),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the current outputs against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.ca) begin
                total++;
                if (A_data !== e.a) begin
                    bad++;
                    $display("FAIL %s A_data: got %h want %h", e.name, A_data, e.a);
                end
            end
            if (e.cb) begin
                total++;
                if (B_data !== e.b) begin
                    bad++;
                    $display("FAIL %s B_data: got %h want %h", e.name, B_data, e.b);
                end
            end
            if (e.cc) begin
                total++;
                if (wb_count !== e.c) begin
                    bad++;
                    $display("FAIL %s wb_count: got %h want %h", e.name, wb_count, e.c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string n,
                              input bit ca, input logic [31:0] a,
                              input bit cb, input logic [31:0] b,
                              input bit cc, input logic [31:0] c);
        exp_t e;
        e.name = n; e.ca = ca; e.a = a; e.cb = cb; e.b = b; e.cc = cc; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic wb(input bit rw, input logic [4:0] da, input logic [1:0] md,
                      input logic [31:0] res, input logic det, input logic [31:0] dd);
        RW_WB = rw; DA_WB = da; MD_WB = md; result = res; determinate = det; DData_next = dd;
    endtask

    task automatic ex(input bit rw, input logic [4:0] da, input logic [31:0] fd);
        RW_EX = rw; DA_EX = da; forward_data = fd;
    endtask

    initial begin
        rst_n = 1'b0;
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        ex(1'b0, 5'd0, 32'd0);
        AA = 5'd0; BA = 5'd0;

        // Reset state
        step();
        AA = 5'd5; BA = 5'd31;
        expect_now("reset_read", 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);
        step();
        // Write attempt while reset held: must be dropped
        wb(1'b1, 5'd5, 2'd0, 32'hDEADBEEF, 1'b0, 32'd0);
        step();
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        AA = 5'd5; BA = 5'd31;
        expect_now("reset_no_write", 1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 32'd0);
        step();

        // MD=0 commit
        wb(1'b1, 5'd3, 2'd0, 32'h12345678, 1'b0, 32'h0BADF00D);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        AA = 5'd3; BA = 5'd3;
        expect_now("md_alu", 1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'd1);
        step();
        // MD=1 commit
        wb(1'b1, 5'd3, 2'd1, 32'h11111111, 1'b0, 32'hCAFEF00D);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_now("md_mem", 1'b1, 32'hCAFEF00D, 1'b0, 32'd0, 1'b1, 32'd2);
        step();
        // MD=2 commit
        wb(1'b1, 5'd3, 2'd2, 32'hFFFF0000, 1'b1, 32'h22222222);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_now("md_slt", 1'b1, 32'h00000001, 1'b0, 32'd0, 1'b1, 32'd3);
        step();
        // MD=3 reserved behaves as result
        wb(1'b1, 5'd4, 2'd3, 32'h00005A5A, 1'b1, 32'h33333333);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        AA = 5'd4; BA = 5'd3;
        expect_now("md_rsv", 1'b1, 32'h00005A5A, 1'b1, 32'h00000001, 1'b1, 32'd4);
        step();

        // Register 0: write dropped, never forwarded
        wb(1'b1, 5'd0, 2'd0, 32'hFFFFFFFF, 1'b0, 32'd0);
        AA = 5'd0; BA = 5'd0;
        expect_now("r0_wb_bypass", 1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        ex(1'b1, 5'd0, 32'hAAAA5555);
        expect_now("r0_ex_fwd", 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 32'd4);
        step();
        ex(1'b0, 5'd0, 32'd0);

        // Write-through bypass
        wb(1'b1, 5'd7, 2'd0, 32'h00000011, 1'b0, 32'd0);
        step();
        wb(1'b1, 5'd7, 2'd0, 32'h00000022, 1'b0, 32'd0);
        AA = 5'd7; BA = 5'd3;
        expect_now("write_through", 1'b1, 32'h00000022, 1'b1, 32'h00000001, 1'b1, 32'd5);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_now("write_through_commit", 1'b1, 32'h00000022, 1'b0, 32'd0, 1'b1, 32'd6);
        step();

        // Execute forward beats write-back
        ex(1'b1, 5'd9, 32'h00000033);
        wb(1'b1, 5'd9, 2'd0, 32'h00000044, 1'b0, 32'd0);
        AA = 5'd9; BA = 5'd9;
        expect_now("fwd_priority", 1'b1, 32'h00000033, 1'b1, 32'h00000033, 1'b0, 32'd0);
        step();
        ex(1'b0, 5'd0, 32'd0);
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        expect_now("fwd_after", 1'b1, 32'h00000044, 1'b1, 32'h00000044, 1'b1, 32'd7);
        step();
        // Execute forward alone does not commit
        ex(1'b1, 5'd12, 32'h00000077);
        AA = 5'd12; BA = 5'd9;
        expect_now("ex_only", 1'b1, 32'h00000077, 1'b1, 32'h00000044, 1'b1, 32'd7);
        step();
        ex(1'b0, 5'd0, 32'd0);
        expect_now("ex_no_commit", 1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 32'd7);
        step();

        // Counter wrap
        force dut.wb_count_r = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_r;
        wb(1'b1, 5'd1, 2'd0, 32'h000000AB, 1'b0, 32'd0);
        step();
        wb(1'b0, 5'd0, 2'd0, 32'd0, 1'b0, 32'd0);
        AA = 5'd1; BA = 5'd7;
        expect_now("count_wrap", 1'b1, 32'h000000AB, 1'b1, 32'h00000022, 1'b1, 32'd0);
        step();

        // Asynchronous reset mid-cycle clears array and counter at once
        rst_n = 1'b0;
        AA = 5'd3; BA = 5'd1;
        expect_now("async_reset", 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_regfile
